// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage: fixed constants and the
// default program held in the instruction ROM.
package if_pkg;

    // mov r0, r0 -- returned for fetches outside the ROM when bounds checking is built in
    localparam logic [31:0] NOP_INST = 32'hE1A00000;

    // Byte distance between consecutive instruction words
    localparam int unsigned PC_STEP = 4;

    // Default program: word index -> instruction. Unlisted words read as zero.
    function automatic logic [31:0] prog_word(input int unsigned idx);
        logic [31:0] w_word;
        w_word = 32'h00000000;
        case (idx)
            0:       w_word = 32'hE3A00014;  // mov r0, #20
            1:       w_word = 32'hE3A01A01;  // mov r1, #4096
            2:       w_word = 32'hE0800001;  // add r0, r0, r1
            default: w_word = 32'h00000000;
        endcase
        return w_word;
    endfunction

endpackage

// File: rtl/if_if.sv
// Fetch-stage bus: redirect/stall controls in, PC+4 and instruction out.
// master = the side driving branch/stall (EX, hazard unit); slave = the fetch stage.
interface if_if #(
    parameter int unsigned DATA_W = 32
);
    logic              branchTaken;
    logic              hazard;
    logic [DATA_W-1:0] branchAddress;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] inst;

    modport master (
        output branchTaken,
        output hazard,
        output branchAddress,
        input  pc,
        input  inst
    );

    modport slave (
        input  branchTaken,
        input  hazard,
        input  branchAddress,
        output pc,
        output inst
    );
endinterface

// File: rtl/if_imem.sv
// Combinational instruction ROM, zero-cycle read, contents from if_pkg::prog_word.
// Optional build macro IF_BOUNDS_CHECK_EN: addresses at or beyond the ROM return a NOP
// instead of wrapping modulo IMEM_WORDS.
module if_imem
    import if_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned IMEM_WORDS = 64
) (
    input  logic [DATA_W-1:0] i_addr,
    output logic [31:0]       o_inst
);

    localparam int unsigned IDX_W = $clog2(IMEM_WORDS);

    logic [IDX_W-1:0] w_idx;
    logic [31:0]      w_rom_word;

    // Byte offset bits are ignored; misaligned addresses read the containing word
    assign w_idx = i_addr[2 +: IDX_W];

    // ROM lookup
    always_comb begin
        w_rom_word = prog_word(32'(w_idx));
    end

`ifdef IF_BOUNDS_CHECK_EN
    logic w_out_of_range;
    logic w_unused_addr;

    assign w_out_of_range = (i_addr >= DATA_W'(4 * IMEM_WORDS));
    assign w_unused_addr  = ^i_addr[1:0];

    // Substitute a NOP for fetches past the end of the ROM
    always_comb begin
        o_inst = w_out_of_range ? NOP_INST : w_rom_word;
    end
`else
    logic w_unused_addr;

    // Upper address bits are dropped so the fetch address wraps around the ROM
    assign w_unused_addr = ^{i_addr[1:0], i_addr[DATA_W-1:2+IDX_W]};

    // Plain ROM output
    always_comb begin
        o_inst = w_rom_word;
    end
`endif

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and the +4 adder.
// Outputs PC+4 and the instruction at PC combinationally to the IF/ID register.
// Optional build macro IF_BOUNDS_CHECK_EN (see if_imem) only changes out-of-range fetches.
module if_stage
    import if_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned IMEM_WORDS = 64
) (
    input  logic clk,
    input  logic rst,
    if_if.slave  bus
);

    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] w_pc_plus4;
    logic [31:0]       w_inst;

    // Wraps silently at the top of the address space
    assign w_pc_plus4 = r_pc + DATA_W'(PC_STEP);

    // PC update: reset, then branch (overrides a stall), then hold on stall, else step
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= '0;
        end else if (bus.branchTaken) begin
            r_pc <= bus.branchAddress;
        end else if (!bus.hazard) begin
            r_pc <= w_pc_plus4;
        end
    end

    if_imem #(
        .DATA_W     (DATA_W),
        .IMEM_WORDS (IMEM_WORDS)
    ) u_imem (
        .i_addr (r_pc),
        .o_inst (w_inst)
    );

    assign bus.pc   = w_pc_plus4;
    assign bus.inst = DATA_W'(w_inst);

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage. A reference PC model pushes the expected
// {pc, inst} for every clock edge; each scenario pops and compares after the edge.
module tb_if_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    if_if #(.DATA_W(32)) bus ();

    if_stage #(
        .DATA_W     (32),
        .IMEM_WORDS (64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [31:0] m_pc = 32'h0;
    int          errors = 0;
    int          checks = 0;

    // Reference ROM: three program words, zeros elsewhere, 64-word depth
    function automatic logic [31:0] model_inst(input logic [31:0] a);
        logic [5:0] idx;
        idx = a[7:2];
`ifdef IF_BOUNDS_CHECK_EN
        if (a >= 32'd256) return 32'hE1A00000;
`endif
        case (idx)
            6'd0:    return 32'hE3A00014;
            6'd1:    return 32'hE3A01A01;
            6'd2:    return 32'hE0800001;
            default: return 32'h00000000;
        endcase
    endfunction

    // Drive one edge's inputs, advance the model, queue the expectation, sample after the edge
    task automatic drive_edge(input logic r, input logic br, input logic hz,
                              input logic [31:0] addr);
        rst               = r;
        bus.branchTaken   = br;
        bus.hazard        = hz;
        bus.branchAddress = addr;
        if (r)        m_pc = 32'h0;
        else if (br)  m_pc = addr;
        else if (!hz) m_pc = m_pc + 32'd4;
        sb.push_back('{pc: m_pc + 32'd4, inst: model_inst(m_pc)});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [31:0] want_pc   [3];
        logic [31:0] want_inst [3];
        want_pc   = '{32'h4, 32'h8, 32'hC};
        want_inst = '{32'hE3A00014, 32'hE3A01A01, 32'hE0800001};
        for (int i = 0; i < 3; i++) begin
            drive_edge(i == 0, 1'b0, 1'b0, 32'h0);
            e = sb.pop_front();
            checks++;
            if (bus.pc !== e.pc || bus.pc !== want_pc[i]) begin
                errors++;
                $display("FAIL reset_seq_pc[%0d]: got %h want %h", i, bus.pc, want_pc[i]);
            end
            checks++;
            if (bus.inst !== e.inst || bus.inst !== want_inst[i]) begin
                errors++;
                $display("FAIL reset_seq_inst[%0d]: got %h want %h", i, bus.inst, want_inst[i]);
            end
        end
    endtask

    task automatic test_free_run;
        logic [31:0] prev_pc;
        drive_edge(1'b1, 1'b0, 1'b0, 32'h0);
        void'(sb.pop_front());
        prev_pc = bus.pc;
        for (int i = 0; i < 50; i++) begin
            drive_edge(1'b0, 1'b0, 1'b0, 32'h0);
            e = sb.pop_front();
            checks++;
            if (bus.pc !== e.pc || bus.pc !== prev_pc + 32'd4) begin
                errors++;
                $display("FAIL free_run_pc[%0d]: got %h want %h", i, bus.pc, e.pc);
            end
            checks++;
            if (bus.inst !== e.inst) begin
                errors++;
                $display("FAIL free_run_inst[%0d]: got %h want %h", i, bus.inst, e.inst);
            end
            prev_pc = bus.pc;
        end
    endtask

    task automatic test_hazard;
        drive_edge(1'b1, 1'b0, 1'b0, 32'h0);
        void'(sb.pop_front());
        drive_edge(1'b0, 1'b0, 1'b0, 32'h0);
        void'(sb.pop_front());
        for (int i = 0; i < 3; i++) begin
            drive_edge(1'b0, 1'b0, 1'b1, 32'h0);
            e = sb.pop_front();
            checks++;
            if (bus.pc !== e.pc || bus.pc !== 32'h8) begin
                errors++;
                $display("FAIL hazard_hold_pc[%0d]: got %h want %h", i, bus.pc, 32'h8);
            end
            checks++;
            if (bus.inst !== e.inst || bus.inst !== 32'hE3A01A01) begin
                errors++;
                $display("FAIL hazard_hold_inst[%0d]: got %h want %h", i, bus.inst, e.inst);
            end
        end
        drive_edge(1'b0, 1'b0, 1'b0, 32'h0);
        e = sb.pop_front();
        checks++;
        if (bus.pc !== e.pc || bus.pc !== 32'hC) begin
            errors++;
            $display("FAIL hazard_release_pc: got %h want %h", bus.pc, 32'hC);
        end
    endtask

    task automatic test_branch;
        drive_edge(1'b0, 1'b0, 1'b0, 32'h0);
        drive_edge(1'b0, 1'b0, 1'b0, 32'h0);
        void'(sb.pop_front());
        void'(sb.pop_front());
        drive_edge(1'b0, 1'b1, 1'b0, 32'h4);
        drive_edge(1'b0, 1'b0, 1'b0, 32'h0);
        drive_edge(1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            // expectations were queued as stimulus went in; only the last edge is live
            e = sb.pop_front();
            if (i == 2) begin
                checks++;
                if (bus.pc !== e.pc || bus.pc !== 32'h10) begin
                    errors++;
                    $display("FAIL branch_resume_pc: got %h want %h", bus.pc, 32'h10);
                end
            end
        end
        drive_edge(1'b0, 1'b1, 1'b0, 32'h4);
        e = sb.pop_front();
        checks++;
        if (bus.pc !== e.pc || bus.pc !== 32'h8) begin
            errors++;
            $display("FAIL branch_pc: got %h want %h", bus.pc, 32'h8);
        end
        checks++;
        if (bus.inst !== e.inst || bus.inst !== 32'hE3A01A01) begin
            errors++;
            $display("FAIL branch_inst: got %h want %h", bus.inst, 32'hE3A01A01);
        end
    endtask

    task automatic test_branch_vs_stall;
        drive_edge(1'b0, 1'b1, 1'b1, 32'h0);
        e = sb.pop_front();
        checks++;
        if (bus.pc !== e.pc || bus.pc !== 32'h4) begin
            errors++;
            $display("FAIL branch_over_stall_pc: got %h want %h", bus.pc, 32'h4);
        end
        checks++;
        if (bus.inst !== e.inst || bus.inst !== 32'hE3A00014) begin
            errors++;
            $display("FAIL branch_over_stall_inst: got %h want %h", bus.inst, 32'hE3A00014);
        end
    endtask

    task automatic test_reset_priority;
        drive_edge(1'b0, 1'b0, 1'b0, 32'h0);
        void'(sb.pop_front());
        drive_edge(1'b1, 1'b1, 1'b0, 32'h10);
        e = sb.pop_front();
        checks++;
        if (bus.pc !== e.pc || bus.pc !== 32'h4) begin
            errors++;
            $display("FAIL reset_over_branch_pc: got %h want %h", bus.pc, 32'h4);
        end
        drive_edge(1'b0, 1'b0, 1'b0, 32'h0);
        void'(sb.pop_front());
        drive_edge(1'b1, 1'b1, 1'b1, 32'h10);
        e = sb.pop_front();
        checks++;
        if (bus.pc !== e.pc || bus.inst !== e.inst) begin
            errors++;
            $display("FAIL reset_over_all: got pc %h inst %h want pc %h inst %h",
                     bus.pc, bus.inst, e.pc, e.inst);
        end
    endtask

    task automatic test_out_of_range;
        logic [31:0] want;
`ifdef IF_BOUNDS_CHECK_EN
        want = 32'hE1A00000;
`else
        want = 32'hE3A00014;
`endif
        drive_edge(1'b0, 1'b1, 1'b0, 32'h100);
        e = sb.pop_front();
        checks++;
        if (bus.pc !== e.pc || bus.pc !== 32'h104) begin
            errors++;
            $display("FAIL oob_pc: got %h want %h", bus.pc, 32'h104);
        end
        checks++;
        if (bus.inst !== e.inst || bus.inst !== want) begin
            errors++;
            $display("FAIL oob_inst: got %h want %h", bus.inst, want);
        end
        // Top of address space: pc output wraps to 0, then PC_reg itself wraps
        drive_edge(1'b0, 1'b1, 1'b0, 32'hFFFFFFFC);
        e = sb.pop_front();
        checks++;
        if (bus.pc !== e.pc || bus.pc !== 32'h0) begin
            errors++;
            $display("FAIL wrap_pc_out: got %h want %h", bus.pc, 32'h0);
        end
        checks++;
        if (bus.inst !== e.inst) begin
            errors++;
            $display("FAIL wrap_inst: got %h want %h", bus.inst, e.inst);
        end
        drive_edge(1'b0, 1'b0, 1'b0, 32'h0);
        e = sb.pop_front();
        checks++;
        if (bus.pc !== e.pc || bus.pc !== 32'h4 || bus.inst !== 32'hE3A00014) begin
            errors++;
            $display("FAIL wrap_step: got pc %h inst %h want pc %h inst %h",
                     bus.pc, bus.inst, 32'h4, 32'hE3A00014);
        end
    endtask

    initial begin
        bus.branchTaken   = 1'b0;
        bus.hazard        = 1'b0;
        bus.branchAddress = 32'h0;
        test_reset();
        test_free_run();
        test_hazard();
        test_branch();
        test_branch_vs_stall();
        test_reset_priority();
        test_out_of_range();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
